// File: rtl/data_axi_bridge.sv
// data_axi_bridge: bridges the core's data-SRAM request port to single-beat AXI reads/writes,
// one transaction outstanding, stalling the pipeline until the DONE cycle.
module data_axi_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
   state_t      state;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wen_q;
   logic        aw_done, w_done, aw_fire, w_fire;
   logic [2:0]  lanes;
   logic        unused;
   assign unused = ^{rresp, bresp};
   assign lanes = 3'(wen_q[0]) + 3'(wen_q[1]) + 3'(wen_q[2]) + 3'(wen_q[3]);
   assign awsize = lanes == 3'd1 ? 3'd0 : lanes == 3'd2 ? 3'd1 : 3'd2;
   assign arsize = 3'd2;
   assign araddr = addr_q;
   assign awaddr = addr_q;
   assign wdata = wdata_q;
   assign wstrb = wen_q;
   assign aw_fire = awvalid & awready;
   assign w_fire = wvalid & wready;
   assign stallreq = data_sram_en & (state != DONE);
   // Valid/ready outputs are registers set on state entry, so no AXI input reaches them combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         addr_q <= '0;
         wdata_q <= '0;
         wen_q <= '0;
         aw_done <= 1'b0;
         w_done <= 1'b0;
         arvalid <= 1'b0;
         rready <= 1'b0;
         awvalid <= 1'b0;
         wvalid <= 1'b0;
         bready <= 1'b0;
         data_sram_rdata <= '0;
      end else begin
         case (state)
            IDLE: if (data_sram_en) begin
               addr_q <= data_sram_addr;
               wdata_q <= data_sram_wdata;
               wen_q <= data_sram_wen;
               aw_done <= 1'b0;
               w_done <= 1'b0;
               if (data_sram_wen == 4'h0) begin
                  state <= RD_ADDR;
                  arvalid <= 1'b1;
               end else begin
                  state <= WR_REQ;
                  awvalid <= 1'b1;
                  wvalid <= 1'b1;
               end
            end
            RD_ADDR: if (arready) begin
               arvalid <= 1'b0;
               rready <= 1'b1;
               state <= RD_DATA;
            end
            RD_DATA: if (rvalid) begin
               rready <= 1'b0;
               data_sram_rdata <= rdata;
               state <= DONE;
            end
            WR_REQ: begin
               if (aw_fire) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_fire) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               if ((aw_done | aw_fire) & (w_done | w_fire)) begin
                  bready <= 1'b1;
                  state <= WR_RESP;
               end
            end
            WR_RESP: if (bvalid) begin
               bready <= 1'b0;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_axi_bridge.sv
// tb_data_axi_bridge: scenario tasks drive the core port and act as the AXI slave,
// checking completions against queued expectations.
module tb_data_axi_bridge;
   logic        clk = 1'b0, rst = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  wen = '0;
   logic [31:0] addr = '0, wd = '0;
   logic [31:0] data_sram_rdata;
   logic        stallreq;
   logic [31:0] araddr, awaddr, wdata, rdata = '0;
   logic [2:0]  arsize, awsize;
   logic        arvalid, rready, awvalid, wvalid, bready;
   logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [3:0]  wstrb;
   int          checks = 0, errors = 0;
   typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] s; logic [2:0] z;} wr_t;
   logic [31:0] rd_q[$];
   wr_t         wr_q[$];

   always #5 clk = ~clk;

   data_axi_bridge dut (
      .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
      .data_sram_wdata(wd), .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
      .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(2'b00), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(2'b00), .bvalid(bvalid), .bready(bready)
   );

   task automatic go_idle(input int n);
      en = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int ar_wait, output int stall);
      int ar_n = 0;
      bit done = 0;
      logic [31:0] exp;
      en = 1'b1; wen = 4'h0; addr = a;
      rd_q.push_back(d);
      stall = 0;
      #1;
      if (stallreq) stall++;
      for (int n = 0; n < 50 && !done; n++) begin
         @(posedge clk); #1;
         if (arvalid) begin
            checks++;
            if (araddr !== a || arsize !== 3'd2) begin
               errors++;
               $display("FAIL ar_fields: araddr=%h arsize=%0d, want %h / 2", araddr, arsize, a);
            end
            arready = (ar_wait == 0);
            if (ar_wait > 0) ar_wait--; else ar_n++;
         end else arready = 1'b0;
         rvalid = rready;
         rdata = rready ? d : 32'h0;
         if (stallreq) stall++; else done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL read_timeout: no DONE within 50 cycles for addr %h", a);
      end
      checks++;
      if (ar_n != 1) begin
         errors++;
         $display("FAIL ar_beats: got %0d AR handshakes, want 1", ar_n);
      end
      exp = rd_q.pop_front();
      checks++;
      if (data_sram_rdata !== exp) begin
         errors++;
         $display("FAIL read_data: data_sram_rdata=%h, want %h", data_sram_rdata, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic [2:0] z,
                           input int aw_wait, input int w_wait, input int b_wait, output int stall);
      int aw_n = 0, w_n = 0, aw_c = 0, w_c = 0, b_c = 0;
      int aw0 = aw_wait, w0 = w_wait, b0 = b_wait;
      bit done = 0;
      wr_t e;
      en = 1'b1; wen = s; addr = a; wd = d;
      wr_q.push_back('{a, d, s, z});
      stall = 0;
      #1;
      if (stallreq) stall++;
      for (int n = 0; n < 60 && !done; n++) begin
         @(posedge clk); #1;
         if (awvalid) begin
            aw_c++;
            checks++;
            if (awaddr !== wr_q[0].a || awsize !== wr_q[0].z) begin
               errors++;
               $display("FAIL aw_fields: awaddr=%h awsize=%0d, want %h / %0d", awaddr, awsize, wr_q[0].a, wr_q[0].z);
            end
            awready = (aw_wait == 0);
            if (aw_wait > 0) aw_wait--; else aw_n++;
         end else awready = 1'b0;
         if (wvalid) begin
            w_c++;
            checks++;
            if (wdata !== wr_q[0].d || wstrb !== wr_q[0].s) begin
               errors++;
               $display("FAIL w_fields: wdata=%h wstrb=%b, want %h / %b", wdata, wstrb, wr_q[0].d, wr_q[0].s);
            end
            wready = (w_wait == 0);
            if (w_wait > 0) w_wait--; else w_n++;
         end else wready = 1'b0;
         if (bready) begin
            b_c++;
            checks++;
            if (aw_n != 1 || w_n != 1 || awvalid || wvalid) begin
               errors++;
               $display("FAIL bready_early: bready=1 with aw_n=%0d w_n=%0d awvalid=%b wvalid=%b, want after both beats", aw_n, w_n, awvalid, wvalid);
            end
            bvalid = (b_wait == 0);
            if (b_wait > 0) b_wait--;
         end else bvalid = 1'b0;
         if (stallreq) stall++; else done = 1;
      end
      e = wr_q.pop_front();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL write_timeout: no DONE within 60 cycles for addr %h", e.a);
      end
      checks++;
      if (aw_n != 1 || w_n != 1) begin
         errors++;
         $display("FAIL write_beats: aw=%0d w=%0d, want 1 / 1", aw_n, w_n);
      end
      checks++;
      if (aw_c != aw0 + 1 || w_c != w0 + 1 || b_c != b0 + 1) begin
         errors++;
         $display("FAIL valid_cycles: awvalid=%0d wvalid=%0d bready=%0d cycles, want %0d / %0d / %0d", aw_c, w_c, b_c, aw0 + 1, w0 + 1, b0 + 1);
      end
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({arvalid, rready, awvalid, wvalid, bready, stallreq} !== 6'b0 || data_sram_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: ar/r/aw/w/b/stall=%b rdata=%h, want 000000 / 0", {arvalid, rready, awvalid, wvalid, bready, stallreq}, data_sram_rdata);
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_read;
      int s;
      do_read(32'h1000, 32'hDEADBEEF, 0, s);
      checks++;
      if (s != 3) begin
         errors++;
         $display("FAIL read_stall: %0d stall cycles, want 3", s);
      end
      go_idle(3);
      checks++;
      if (data_sram_rdata !== 32'hDEADBEEF || stallreq !== 1'b0) begin
         errors++;
         $display("FAIL read_hold: rdata=%h stallreq=%b, want deadbeef / 0", data_sram_rdata, stallreq);
      end
      do_read(32'h1ABC, 32'h0F0F1234, 2, s);
      checks++;
      if (s != 5) begin
         errors++;
         $display("FAIL read_slow_ar: %0d stall cycles, want 5", s);
      end
      go_idle(1);
   endtask

   task automatic test_word_store;
      int s;
      do_write(32'h2004, 4'hF, 32'h12345678, 3'd2, 0, 2, 0, s);
      checks++;
      if (s != 5) begin
         errors++;
         $display("FAIL word_store_stall: %0d stall cycles, want 5", s);
      end
      go_idle(1);
   endtask

   task automatic test_narrow_stores;
      int s;
      do_write(32'h3002, 4'b0100, 32'h00AB0000, 3'd0, 0, 0, 0, s);
      go_idle(1);
      do_write(32'h3010, 4'b0011, 32'h0000BEEF, 3'd1, 1, 0, 1, s);
      checks++;
      if (s != 5) begin
         errors++;
         $display("FAIL half_store_stall: %0d stall cycles, want 5", s);
      end
      go_idle(1);
      do_write(32'h3020, 4'b0111, 32'h00112233, 3'd2, 0, 0, 0, s);
      go_idle(1);
   endtask

   task automatic test_back_to_back;
      int s;
      do_read(32'h5000, 32'hA5A55A5A, 0, s);
      do_write(32'h5008, 4'hF, 32'h87654321, 3'd2, 0, 0, 0, s);
      checks++;
      if (s != 3) begin
         errors++;
         $display("FAIL b2b_stall: store took %0d stall cycles, want 3", s);
      end
      checks++;
      if (data_sram_rdata !== 32'hA5A55A5A) begin
         errors++;
         $display("FAIL b2b_rdata_hold: rdata=%h, want a5a55a5a", data_sram_rdata);
      end
      go_idle(1);
   endtask

   task automatic test_reset_mid;
      int s;
      bit hit = 0;
      en = 1'b1; wen = 4'h0; addr = 32'h4000;
      for (int n = 0; n < 10 && !hit; n++) begin
         @(posedge clk); #1;
         arready = arvalid;
         hit = rready;
      end
      arready = 1'b0;
      rst = 1'b1;
      en = 1'b0;
      #1;
      checks++;
      if (!hit || arvalid !== 1'b0 || rready !== 1'b0 || stallreq !== 1'b0 || data_sram_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: reached=%b arvalid=%b rready=%b stallreq=%b rdata=%h, want 1/0/0/0/0", hit, arvalid, rready, stallreq, data_sram_rdata);
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      do_read(32'h4000, 32'hCAFEF00D, 0, s);
      checks++;
      if (s != 3) begin
         errors++;
         $display("FAIL reset_fresh_read: %0d stall cycles, want 3", s);
      end
      go_idle(1);
   endtask

   task automatic test_bvalid_delay;
      int s;
      do_write(32'h6000, 4'hF, 32'h0BADF00D, 3'd2, 0, 0, 5, s);
      checks++;
      if (s != 8) begin
         errors++;
         $display("FAIL bvalid_delay_stall: %0d stall cycles, want 8", s);
      end
      go_idle(1);
      checks++;
      if (bready !== 1'b0) begin
         errors++;
         $display("FAIL bready_after: bready=%b, want 0", bready);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_word_store();
      test_narrow_stores();
      test_back_to_back();
      test_reset_mid();
      test_bvalid_delay();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_axi_bridge.md
DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

Interface
REQ-001 Parameter: none; AXI channel IDs, burst length and burst type are fixed at zero/single-beat and are not exposed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 data_sram_en  in  1  core data request valid; held stable by the core while stallreq=1.
REQ-005 data_sram_wen  in  4  byte write strobes; 0 means read.
REQ-006 data_sram_addr  in  32  byte address, passed unchanged to AXI.
REQ-007 data_sram_wdata  in  32  store data, byte-lane aligned by the core.
REQ-008 data_sram_rdata  out  32  registered load data returned to the MEM stage.
REQ-009 stallreq  out  1  pipeline stall request to CTRL.
REQ-010 araddr/arsize/arvalid  out  32/3/1; arready  in  1  AXI read-address channel.
REQ-011 rdata/rresp/rvalid  in  32/2/1; rready  out  1  AXI read-data channel.
REQ-012 awaddr/awsize/awvalid  out  32/3/1; awready  in  1  AXI write-address channel.
REQ-013 wdata/wstrb/wvalid  out  32/4/1; wready  in  1  AXI write-data channel.
REQ-014 bresp/bvalid  in  2/1; bready  out  1  AXI write-response channel.

Function
REQ-015 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; exactly one transaction outstanding at any time.
REQ-016 IDLE: en=1 and wen=0 -> RD_ADDR; en=1 and wen!=0 -> WR_REQ; addr, wdata, wen latched on that edge; en=0 -> stay IDLE.
REQ-017 RD_ADDR: arvalid=1, araddr=latched addr, arsize=3'd2; arvalid=1 and arready=1 -> RD_DATA.
REQ-018 RD_DATA: rready=1; rvalid=1 -> capture rdata into data_sram_rdata, go to DONE; rresp is ignored.
REQ-019 WR_REQ: awvalid and wvalid both asserted on entry; each deasserts independently after its own handshake (sticky aw_done/w_done flags); when both are done (same or different cycles) -> WR_RESP.
REQ-020 awsize is derived from the latched strobes: 1 lane set -> 0, 2 lanes -> 1, 4 lanes -> 2; other patterns -> 2.
REQ-021 wstrb = latched wen; wdata = latched wdata; awaddr = latched addr.
REQ-022 WR_RESP: bready=1; bvalid=1 -> DONE; bresp is ignored.
REQ-023 DONE: lasts exactly 1 cycle, then IDLE; data_sram_rdata holds its last captured value until the next read capture.
REQ-024 stallreq = data_sram_en & (state != DONE), combinational; the core advances in the DONE cycle.
REQ-025 Minimum read latency: request seen in IDLE at cycle 0; AR handshake at cycle 1; R at cycle 2; DONE at cycle 3 with stallreq=0.
REQ-026 A request presented in the cycle immediately after DONE (state=IDLE) is accepted with no bubble.
REQ-027 en dropping mid-transaction does not abort it; the AXI transaction completes and the FSM returns to IDLE.
REQ-028 Handshake signals (valid/ready outputs) come from registers or state decode only, never combinationally from the same-cycle AXI input.

Reset
REQ-029 rst=1 asynchronously forces IDLE, clears aw_done/w_done, and zeroes all valid/ready outputs and data_sram_rdata.
REQ-030 Reset mid-transaction abandons it without completion; the first request after reset release is treated as new.

Verification
REQ-031 Read, arready=rready=1 always: en=1, wen=0, addr=0x1000, rdata=0xDEADBEEF -> araddr=0x1000, stallreq=1 for 3 cycles, then data_sram_rdata=0xDEADBEEF with stallreq=0.
REQ-032 Word store, awready high two cycles before wready: wen=4'hF, addr=0x2004, wdata=0x12345678 -> awvalid drops after its handshake, wvalid stays high until wready, exactly one AW and one W beat, awsize=2, WR_RESP after both complete.
REQ-033 Byte store wen=4'b0100 -> awsize=0, wstrb=4'b0100; halfword store wen=4'b0011 -> awsize=1.
REQ-034 Back-to-back: read completes at DONE, a store is presented the next cycle -> store accepted from IDLE, no extra stall cycle.
REQ-035 rst asserted during RD_DATA -> arvalid/rready/stallreq-producing state drop immediately; the next read after reset issues a fresh AR.
REQ-036 bvalid delayed 5 cycles -> stallreq stays 1 throughout, bready=1 only in WR_RESP.
